// File: rtl/rx_bit_timer.sv
// USB receive bit-timing recovery: locks onto d_edge pulses, strobes shift_enable
// once per bit at a fixed phase, and counts bits into bytes.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | receiver disabled, counters held at zero
// WAIT_EDGE | enabled, waiting for the first d_plus edge
// RUN       | bit timing acquired, phase counter free-running
module rx_bit_timer #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_PHASE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       d_edge,
   output logic       shift_enable,
   output logic [2:0] bit_count,
   output logic       byte_received,
   output logic       locked
);

   localparam int PW = $clog2(CLKS_PER_BIT);
   localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);
   localparam logic [PW-1:0] PH_ONE    = PW'(1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_EDGE,
      RUN
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] phase, phase_nxt;
   logic [2:0]    bit_count_nxt;
   logic          byte_received_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         phase         <= '0;
         bit_count     <= 3'd0;
         byte_received <= 1'b0;
         locked        <= 1'b0;
      end else begin
         state         <= state_nxt;
         phase         <= phase_nxt;
         bit_count     <= bit_count_nxt;
         byte_received <= byte_received_nxt;
         locked        <= (state_nxt == RUN);
      end
   end

   // The cycle carrying d_edge is phase 0, so an edge always reloads phase 1.
   always_comb begin
      state_nxt         = state;
      phase_nxt         = '0;
      bit_count_nxt     = bit_count;
      byte_received_nxt = 1'b0;
      shift_enable      = (state == RUN) && enable && (phase == PH_SAMPLE);

      case (state)
         IDLE: begin
            bit_count_nxt = 3'd0;
            if (enable) state_nxt = WAIT_EDGE;
         end
         WAIT_EDGE: begin
            bit_count_nxt = 3'd0;
            if (!enable) begin
               state_nxt = IDLE;
            end else if (d_edge) begin
               state_nxt = RUN;
               phase_nxt = PH_ONE;
            end
         end
         RUN: begin
            if (!enable) begin
               state_nxt     = IDLE;
               bit_count_nxt = 3'd0;
            end else begin
               if (d_edge)                phase_nxt = PH_ONE;
               else if (phase == PH_LAST) phase_nxt = '0;
               else                       phase_nxt = phase + PH_ONE;
               if (shift_enable) begin
                  bit_count_nxt     = bit_count + 3'd1;
                  byte_received_nxt = (bit_count == 3'd7);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
